mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arbiter
//  Purpose  : Two-port (CPU / debug loader) arbiter in front of an
//             asynchronous SRAM. Each port owns a one-entry command register;
//             a round-robin FSM (IDLE -> ACCESS -> DONE) serves one command
//             at a time with active-low SRAM strobes.
//  Ports    : Clk, Reset (async, active-low)
//             cpu_* : req/we/addr/wdata in, rdy/ack/rdata out
//             dbg_* : same semantics as the CPU port
//             Mem_* : active-low CE/UB/LB/OE/WE, ADDR, Dout, Dout_en out,
//                     Din in
//             busy  : high whenever the FSM is not IDLE
//  Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
  parameter int ACCESS_CYCLES = 2  // strobe width in cycles, legal 1..7
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  output logic        cpu_rdy,
  output logic        cpu_ack,
  output logic [15:0] cpu_rdata,
  input  logic        dbg_req,
  input  logic        dbg_we,
  input  logic [15:0] dbg_addr,
  input  logic [15:0] dbg_wdata,
  output logic        dbg_rdy,
  output logic        dbg_ack,
  output logic [15:0] dbg_rdata,
  output logic        Mem_CE,
  output logic        Mem_UB,
  output logic        Mem_LB,
  output logic        Mem_OE,
  output logic        Mem_WE,
  output logic [15:0] Mem_ADDR,
  output logic [15:0] Mem_Dout,
  output logic        Mem_Dout_en,
  input  logic [15:0] Mem_Din,
  output logic        busy
);

  localparam logic [2:0] C_CNT_LOAD = 3'(ACCESS_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  state_t      r_state;
  logic [2:0]  r_cnt;

  logic        r_cpu_pend, r_cpu_we;
  logic [15:0] r_cpu_addr, r_cpu_wdata;
  logic        r_dbg_pend, r_dbg_we;
  logic [15:0] r_dbg_addr, r_dbg_wdata;

  logic        r_gnt_dbg;   // port currently in service (1 = dbg)
  logic        r_gnt_we;    // direction of the access in service
  logic        r_last_dbg;  // last port granted; the other wins a tie

  logic        w_dbg_gnt;
  logic        w_sel_we;
  logic [15:0] w_sel_addr, w_sel_wdata;

  // CPU wins unless only dbg is pending, or both are pending and CPU went last.
  assign w_dbg_gnt   = r_dbg_pend & (~r_cpu_pend | ~r_last_dbg);
  assign w_sel_we    = w_dbg_gnt ? r_dbg_we    : r_cpu_we;
  assign w_sel_addr  = w_dbg_gnt ? r_dbg_addr  : r_cpu_addr;
  assign w_sel_wdata = w_dbg_gnt ? r_dbg_wdata : r_cpu_wdata;

  assign cpu_rdy = ~r_cpu_pend;
  assign dbg_rdy = ~r_dbg_pend;
  assign busy    = (r_state != ST_IDLE);

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state     <= ST_IDLE;
      r_cnt       <= 3'd0;
      r_cpu_pend  <= 1'b0;
      r_cpu_we    <= 1'b0;
      r_cpu_addr  <= 16'h0000;
      r_cpu_wdata <= 16'h0000;
      r_dbg_pend  <= 1'b0;
      r_dbg_we    <= 1'b0;
      r_dbg_addr  <= 16'h0000;
      r_dbg_wdata <= 16'h0000;
      r_gnt_dbg   <= 1'b0;
      r_gnt_we    <= 1'b0;
      r_last_dbg  <= 1'b1;
      cpu_ack     <= 1'b0;
      dbg_ack     <= 1'b0;
      cpu_rdata   <= 16'h0000;
      dbg_rdata   <= 16'h0000;
      Mem_CE      <= 1'b1;
      Mem_UB      <= 1'b1;
      Mem_LB      <= 1'b1;
      Mem_OE      <= 1'b1;
      Mem_WE      <= 1'b1;
      Mem_ADDR    <= 16'h0000;
      Mem_Dout    <= 16'h0000;
      Mem_Dout_en <= 1'b0;
    end else begin
      // Command capture: fields are frozen here and never re-sampled.
      if (cpu_req && !r_cpu_pend) begin
        r_cpu_pend  <= 1'b1;
        r_cpu_we    <= cpu_we;
        r_cpu_addr  <= cpu_addr;
        r_cpu_wdata <= cpu_wdata;
      end
      if (dbg_req && !r_dbg_pend) begin
        r_dbg_pend  <= 1'b1;
        r_dbg_we    <= dbg_we;
        r_dbg_addr  <= dbg_addr;
        r_dbg_wdata <= dbg_wdata;
      end

      case (r_state)
        ST_IDLE: begin
          if (r_cpu_pend || r_dbg_pend) begin
            r_state    <= ST_ACCESS;
            r_cnt      <= C_CNT_LOAD;
            r_gnt_dbg  <= w_dbg_gnt;
            r_last_dbg <= w_dbg_gnt;
            r_gnt_we   <= w_sel_we;
            Mem_ADDR   <= w_sel_addr;
            Mem_CE     <= 1'b0;
            Mem_UB     <= 1'b0;
            Mem_LB     <= 1'b0;
            Mem_OE     <= w_sel_we;
            Mem_WE     <= ~w_sel_we;
            if (w_sel_we) begin
              Mem_Dout    <= w_sel_wdata;
              Mem_Dout_en <= 1'b1;
            end
          end
        end

        ST_ACCESS: begin
          if (r_cnt == 3'd0) begin
            r_state <= ST_DONE;
            Mem_CE  <= 1'b1;
            Mem_UB  <= 1'b1;
            Mem_LB  <= 1'b1;
            Mem_OE  <= 1'b1;
            Mem_WE  <= 1'b1;
            // Mem_Dout_en / Mem_Dout / Mem_ADDR stay put through DONE so a
            // write has data hold time after WE rises.
            if (r_gnt_dbg) begin
              dbg_ack <= 1'b1;
              if (!r_gnt_we) dbg_rdata <= Mem_Din;
            end else begin
              cpu_ack <= 1'b1;
              if (!r_gnt_we) cpu_rdata <= Mem_Din;
            end
          end else begin
            r_cnt <= r_cnt - 3'd1;
          end
        end

        ST_DONE: begin
          r_state     <= ST_IDLE;
          cpu_ack     <= 1'b0;
          dbg_ack     <= 1'b0;
          Mem_Dout_en <= 1'b0;
          if (r_gnt_dbg) r_dbg_pend <= 1'b0;
          else           r_cpu_pend <= 1'b0;
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_arbiter
//  Purpose  : Self-checking bench for mem_arbiter. Three instances
//             (ACCESS_CYCLES = 2, 1, 7) share one stimulus stream; each is
//             checked every cycle against a transaction-timing model, plus
//             directed scenarios with literal expectations.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

  localparam int NI = 3;

  function automatic int ac_of(input int i);
    return (i == 0) ? 2 : ((i == 1) ? 1 : 7);
  endfunction

  logic        Clk = 1'b0;
  logic        Reset;
  logic        cpu_req, cpu_we, dbg_req, dbg_we;
  logic [15:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata, Mem_Din;

  logic        cpu_rdy_o [NI], cpu_ack_o [NI], dbg_rdy_o [NI], dbg_ack_o [NI];
  logic [15:0] cpu_rdata_o [NI], dbg_rdata_o [NI];
  logic        Mem_CE_o [NI], Mem_UB_o [NI], Mem_LB_o [NI], Mem_OE_o [NI], Mem_WE_o [NI];
  logic [15:0] Mem_ADDR_o [NI], Mem_Dout_o [NI];
  logic        Mem_Dout_en_o [NI], busy_o [NI];

  always #5 Clk = ~Clk;

  generate
    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
      mem_arbiter #(.ACCESS_CYCLES((gi == 0) ? 2 : ((gi == 1) ? 1 : 7))) u_dut (
        .Clk(Clk), .Reset(Reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdy(cpu_rdy_o[gi]), .cpu_ack(cpu_ack_o[gi]), .cpu_rdata(cpu_rdata_o[gi]),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_rdy(dbg_rdy_o[gi]), .dbg_ack(dbg_ack_o[gi]), .dbg_rdata(dbg_rdata_o[gi]),
        .Mem_CE(Mem_CE_o[gi]), .Mem_UB(Mem_UB_o[gi]), .Mem_LB(Mem_LB_o[gi]),
        .Mem_OE(Mem_OE_o[gi]), .Mem_WE(Mem_WE_o[gi]),
        .Mem_ADDR(Mem_ADDR_o[gi]), .Mem_Dout(Mem_Dout_o[gi]),
        .Mem_Dout_en(Mem_Dout_en_o[gi]), .Mem_Din(Mem_Din), .busy(busy_o[gi])
      );
    end
  endgenerate

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input int inst, input logic [15:0] got,
                     input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s inst%0d got %h exp %h at %0t", nm, inst, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------
  // Reference model: a service is described only by which port holds it
  // and how many cycles have elapsed since the grant (age). Ages 1..AC are
  // the strobe window, age AC+1 is the acknowledge cycle.
  // ---------------------------------------------------------------------
  bit          m_pend  [NI][2];
  bit          m_we    [NI][2];
  logic [15:0] m_addr  [NI][2];
  logic [15:0] m_wd    [NI][2];
  logic [15:0] m_rdata [NI][2];
  bit          m_last  [NI];     // 0 = cpu served last, 1 = dbg
  bit          m_act   [NI];
  int          m_age   [NI];
  int          m_port  [NI];
  logic [15:0] m_maddr [NI];
  logic [15:0] m_mdout [NI];

  always @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < NI; i++) begin
        for (int p = 0; p < 2; p++) begin
          m_pend[i][p] = 0; m_we[i][p] = 0; m_addr[i][p] = 0;
          m_wd[i][p] = 0; m_rdata[i][p] = 0;
        end
        m_last[i] = 1; m_act[i] = 0; m_age[i] = 0; m_port[i] = 0;
        m_maddr[i] = 0; m_mdout[i] = 0;
      end
    end else begin
      for (int i = 0; i < NI; i++) begin
        bit p0, p1;
        int ac, g;
        p0 = m_pend[i][0];
        p1 = m_pend[i][1];
        ac = ac_of(i);
        if (m_act[i]) begin
          if (m_age[i] == ac && !m_we[i][m_port[i]]) m_rdata[i][m_port[i]] = Mem_Din;
          if (m_age[i] == ac + 1) begin
            m_pend[i][m_port[i]] = 0;
            m_act[i] = 0;
          end else begin
            m_age[i]++;
          end
        end else if (p0 || p1) begin
          g = (p0 && p1) ? (m_last[i] ? 0 : 1) : (p0 ? 0 : 1);
          m_act[i] = 1; m_age[i] = 1; m_port[i] = g; m_last[i] = (g == 1);
          m_maddr[i] = m_addr[i][g];
          if (m_we[i][g]) m_mdout[i] = m_wd[i][g];
        end
        if (cpu_req && !p0) begin
          m_pend[i][0] = 1; m_we[i][0] = cpu_we; m_addr[i][0] = cpu_addr; m_wd[i][0] = cpu_wdata;
        end
        if (dbg_req && !p1) begin
          m_pend[i][1] = 1; m_we[i][1] = dbg_we; m_addr[i][1] = dbg_addr; m_wd[i][1] = dbg_wdata;
        end
      end
    end
  end

  // Cycle-by-cycle comparison of every instance against the model.
  always @(negedge Clk) begin
    if (chk_en) begin
      for (int i = 0; i < NI; i++) begin
        bit acc, dn, w;
        acc = m_act[i] && (m_age[i] <= ac_of(i));
        dn  = m_act[i] && (m_age[i] == ac_of(i) + 1);
        w   = m_we[i][m_port[i]];
        chk("ce", i, 16'(Mem_CE_o[i]), 16'(!acc));
        chk("ub", i, 16'(Mem_UB_o[i]), 16'(!acc));
        chk("lb", i, 16'(Mem_LB_o[i]), 16'(!acc));
        chk("oe", i, 16'(Mem_OE_o[i]), 16'(!(acc && !w)));
        chk("we", i, 16'(Mem_WE_o[i]), 16'(!(acc && w)));
        chk("dout_en", i, 16'(Mem_Dout_en_o[i]), 16'(m_act[i] && w));
        chk("busy", i, 16'(busy_o[i]), 16'(m_act[i]));
        chk("cpu_ack", i, 16'(cpu_ack_o[i]), 16'(dn && m_port[i] == 0));
        chk("dbg_ack", i, 16'(dbg_ack_o[i]), 16'(dn && m_port[i] == 1));
        chk("cpu_rdy", i, 16'(cpu_rdy_o[i]), 16'(!m_pend[i][0]));
        chk("dbg_rdy", i, 16'(dbg_rdy_o[i]), 16'(!m_pend[i][1]));
        chk("cpu_rdata", i, cpu_rdata_o[i], m_rdata[i][0]);
        chk("dbg_rdata", i, dbg_rdata_o[i], m_rdata[i][1]);
        if (m_act[i]) chk("addr", i, Mem_ADDR_o[i], m_maddr[i]);
        if (m_act[i] && w) chk("dout", i, Mem_Dout_o[i], m_mdout[i]);
      end
    end
  end

  // ---------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------
  int oe_mask [NI], ack_cyc [NI], we_low [NI], oe_low [NI], ack_cnt [NI];
  int first_ack [NI], dack_cnt [NI], dhold_ok [NI];
  int rnd_cack [NI], rnd_dack [NI];
  int exp_oe_mask [NI] = '{12, 4, 508};
  int exp_ack_cyc [NI] = '{4, 3, 9};

  task automatic idle_inputs();
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    dbg_req = 0; dbg_we = 0; dbg_addr = 0; dbg_wdata = 0;
  endtask

  initial begin
    Reset = 1'b0;
    idle_inputs();
    Mem_Din = 16'h0000;
    repeat (3) @(posedge Clk);
    #2;
    for (int i = 0; i < NI; i++) begin
      chk("rst_rdy", i, 16'(cpu_rdy_o[i] & dbg_rdy_o[i]), 16'h1);
      chk("rst_busy", i, 16'(busy_o[i]), 16'h0);
      chk("rst_strobes", i, 16'({Mem_CE_o[i], Mem_UB_o[i], Mem_LB_o[i], Mem_OE_o[i], Mem_WE_o[i]}), 16'h1f);
      chk("rst_addr", i, Mem_ADDR_o[i], 16'h0000);
      chk("rst_dout", i, Mem_Dout_o[i], 16'h0000);
      chk("rst_dout_en", i, 16'(Mem_Dout_en_o[i]), 16'h0);
    end
    @(negedge Clk);
    Reset = 1'b1;
    chk_en = 1'b1;

    // ---- CPU read 0x1234, SRAM returns 0xBEEF ----
    @(negedge Clk);
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h1234; Mem_Din = 16'hBEEF;
    for (int i = 0; i < NI; i++) begin oe_mask[i] = 0; ack_cyc[i] = -1; end
    for (int k = 1; k <= 12; k++) begin
      @(negedge Clk);
      if (k == 1) cpu_req = 0;
      for (int i = 0; i < NI; i++) begin
        if (!Mem_OE_o[i]) oe_mask[i] |= (1 << k);
        if (cpu_ack_o[i] && ack_cyc[i] < 0) ack_cyc[i] = k;
      end
    end
    for (int i = 0; i < NI; i++) begin
      chk("rd_oe_window", i, 16'(oe_mask[i]), 16'(exp_oe_mask[i]));
      chk("rd_ack_cycle", i, 16'(ack_cyc[i]), 16'(exp_ack_cyc[i]));
      chk("rd_cpu_rdata", i, cpu_rdata_o[i], 16'hBEEF);
      chk("rd_dbg_rdata", i, dbg_rdata_o[i], 16'h0000);
    end

    // ---- dbg write 0x0040 <- 0xA5A5 ----
    @(negedge Clk);
    dbg_req = 1; dbg_we = 1; dbg_addr = 16'h0040; dbg_wdata = 16'hA5A5;
    for (int i = 0; i < NI; i++) begin
      we_low[i] = 0; oe_low[i] = 0; ack_cnt[i] = 0; dhold_ok[i] = 0;
    end
    for (int k = 1; k <= 12; k++) begin
      @(negedge Clk);
      if (k == 1) dbg_req = 0;
      for (int i = 0; i < NI; i++) begin
        if (!Mem_WE_o[i]) we_low[i]++;
        if (!Mem_OE_o[i]) oe_low[i]++;
        if (dbg_ack_o[i]) begin
          ack_cnt[i]++;
          if (Mem_Dout_en_o[i] && Mem_Dout_o[i] == 16'hA5A5 && Mem_ADDR_o[i] == 16'h0040)
            dhold_ok[i] = 1;
        end
      end
    end
    for (int i = 0; i < NI; i++) begin
      chk("wr_we_width", i, 16'(we_low[i]), 16'(ac_of(i)));
      chk("wr_oe_low", i, 16'(oe_low[i]), 16'h0);
      chk("wr_ack_pulses", i, 16'(ack_cnt[i]), 16'h1);
      chk("wr_data_hold", i, 16'(dhold_ok[i]), 16'h1);
    end

    // ---- reset in the middle of a CPU read ----
    @(negedge Clk);
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0100; Mem_Din = 16'h1111;
    @(negedge Clk);
    cpu_req = 0;
    @(posedge Clk);
    #2 Reset = 1'b0;
    #1;
    for (int i = 0; i < NI; i++) begin
      chk("mid_rst_strobes", i, 16'({Mem_CE_o[i], Mem_OE_o[i], Mem_WE_o[i]}), 16'h7);
      chk("mid_rst_ack", i, 16'(cpu_ack_o[i]), 16'h0);
      chk("mid_rst_rdata", i, cpu_rdata_o[i], 16'h0000);
      chk("mid_rst_rdy", i, 16'(cpu_rdy_o[i]), 16'h1);
    end
    @(posedge Clk);
    #2 Reset = 1'b1;

    // ---- simultaneous contest right after reset: CPU first ----
    @(negedge Clk);
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0200;
    dbg_req = 1; dbg_we = 0; dbg_addr = 16'h0300;
    Mem_Din = 16'h5A5A;
    for (int i = 0; i < NI; i++) begin first_ack[i] = -1; ack_cnt[i] = 0; dack_cnt[i] = 0; end
    for (int k = 1; k <= 25; k++) begin
      @(negedge Clk);
      if (k == 1) begin cpu_req = 0; dbg_req = 0; end
      for (int i = 0; i < NI; i++) begin
        if (cpu_ack_o[i]) begin ack_cnt[i]++;  if (first_ack[i] < 0) first_ack[i] = 0; end
        if (dbg_ack_o[i]) begin dack_cnt[i]++; if (first_ack[i] < 0) first_ack[i] = 1; end
      end
    end
    for (int i = 0; i < NI; i++) begin
      chk("contest_first", i, 16'(first_ack[i]), 16'h0);
      chk("contest_both", i, 16'(ack_cnt[i] * 16 + dack_cnt[i]), 16'h11);
      chk("post_rst_rdata", i, cpu_rdata_o[i], 16'h5A5A);
    end

    // ---- randomized traffic, model-checked every cycle ----
    for (int i = 0; i < NI; i++) begin rnd_cack[i] = 0; rnd_dack[i] = 0; end
    for (int n = 0; n < 3000; n++) begin
      @(negedge Clk);
      for (int i = 0; i < NI; i++) begin
        if (cpu_ack_o[i]) rnd_cack[i]++;
        if (dbg_ack_o[i]) rnd_dack[i]++;
      end
      cpu_req   = ($urandom_range(0, 2) != 0);
      cpu_we    = $urandom_range(0, 1) == 1;
      cpu_addr  = 16'($urandom);
      cpu_wdata = 16'($urandom);
      dbg_req   = ($urandom_range(0, 2) != 0);
      dbg_we    = $urandom_range(0, 1) == 1;
      dbg_addr  = 16'($urandom);
      dbg_wdata = 16'($urandom);
      Mem_Din   = 16'($urandom);
    end
    @(negedge Clk);
    idle_inputs();
    repeat (20) @(negedge Clk);
    for (int i = 0; i < NI; i++) begin
      chk("no_starve_cpu", i, 16'(rnd_cack[i] > 20), 16'h1);
      chk("no_starve_dbg", i, 16'(rnd_dack[i] > 20), 16'h1);
    end

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
